stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning stack entries managed.
REQ-002 SHALL have parameter W, default 8, meaning data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, 2, one-cycle request strobe per requester i (0,1); honoured only while ready=1.
REQ-006 SHALL have ports op0/op1, input, 2 each, requester opcode: 00 PUSH, 01 POP, 10 TOS, 11 reserved.
REQ-007 SHALL have ports wdata0/wdata1, input, W each, push data per requester.
REQ-008 SHALL have port ready, output, 1, controller idle and accepting a request.
REQ-009 SHALL have port gnt_id, output, 1, requester being served; valid while ready=0.
REQ-010 SHALL have ports done, err, output, 1 each, completion pulse and error flag for the served request.
REQ-011 SHALL have port rdata, output, W, POP/TOS result.
REQ-012 SHALL have ports depth (clog2(DEPTH)+1 bits), full, empty, outputs, occupancy status.
REQ-013 SHALL have ports stk_push, stk_pop, stk_tos (output, 1), stk_din (output, W), stk_dout (input, W) to the stack; the stack registers stk_dout on the edge ending a stk_pop/stk_tos cycle.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; ready=1 only in IDLE.
REQ-015 IDLE: at an edge with any req bit high, SHALL latch the winner id, its op and its wdata, then enter ISSUE; otherwise remain in IDLE.
REQ-016 Both req bits high: SHALL grant round-robin, i.e. to the requester not granted last; the last-granted register resets to 1, so requester 0 wins the first tie.
REQ-017 req while ready=0 SHALL be ignored and not queued.
REQ-018 ISSUE, legal op: SHALL assert exactly one stk_* strobe for exactly this one cycle, with stk_din = latched wdata for PUSH.
REQ-019 Illegal cases: PUSH when full; POP or TOS when empty; op 11. SHALL assert no strobe, set err=1 and go to DONE.
REQ-020 Next state after ISSUE: PUSH goes to DONE; POP and TOS go to WAIT.
REQ-021 WAIT: SHALL capture stk_dout into rdata at the edge ending WAIT, then enter DONE.
REQ-022 DONE: done=1 for one cycle, err valid, then IDLE.
REQ-023 Latency from the req edge: PUSH done in 2nd cycle after; POP/TOS done in 3rd cycle after; errors done in 2nd cycle after.
REQ-024 depth: +1 at the edge ending a legal PUSH ISSUE; -1 at a legal POP; TOS leaves it unchanged.
REQ-025 depth SHALL never leave the range 0..DEPTH.
REQ-026 full = (depth==DEPTH); empty = (depth==0).
REQ-027 rdata SHALL hold its last value; it is unchanged by PUSH or error transactions.
REQ-028 stk_* strobes SHALL be 0 in every state except ISSUE.

Reset
REQ-029 rst low SHALL immediately force: state IDLE, ready=1, done=0, err=0, gnt_id=0, rdata=0, depth=0, empty=1, full=0, stk_* strobes 0, stk_din=0, last-granted=1.
REQ-030 Reset in any state SHALL abandon the transaction with no done pulse.
REQ-031 The stack SHALL be reset from the same rst, inverted externally as needed, so depth and stack pointer agree.

Structure
REQ-032 Package stack_ctrl_pkg SHALL hold the opcode constants, the FSM state enum and the DEPTH/W defaults.
REQ-033 A sub-module rr_arb2 SHALL hold the two-requester round-robin arbiter: inputs req[1:0] and update enable, output grant id.
REQ-034 Stack storage SHALL remain outside this block.

Verification
REQ-035 After reset, req[0]=1 with op0=PUSH and wdata0=8'h5A: stk_push=1 with stk_din=5A in cycle 1; done=1, err=0, depth=1 in cycle 2.
REQ-036 After reset, req=2'b11 both with PUSH: gnt_id=0 served first; second transaction request with req=2'b11 again: gnt_id=1.
REQ-037 Empty stack, op1=POP: no stk_pop strobe, done=1 and err=1 in cycle 2, depth stays 0.
REQ-038 Eight PUSHes then a ninth: ninth returns err=1 with no stk_push; full=1 and depth=8 throughout.
REQ-039 After PUSH A5 then TOS: rdata=A5 at done in cycle 3 and depth unchanged; a following POP decrements depth by 1.
REQ-040 rst asserted while in WAIT: immediate IDLE with ready=1 and depth=0; no done pulse; the next request is served normally.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and default sizes for the stack controller.
// Pure declarations: no latency or backpressure of its own.
package stack_ctrl_pkg;

   localparam int DEF_DEPTH = 8;
   localparam int DEF_W     = 8;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_TOS  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/stack_ctrl_if.sv
// Requester-side bus of the stack controller: two request ports, grant and result.
// No storage; requests are only honoured while ready is high.
interface stack_ctrl_if
   import stack_ctrl_pkg::*;
#(
   parameter int W = DEF_W
);
   logic [1:0]   req;
   logic [1:0]   op0;
   logic [1:0]   op1;
   logic [W-1:0] wdata0;
   logic [W-1:0] wdata1;
   logic         ready;
   logic         gnt_id;
   logic         done;
   logic         err;
   logic [W-1:0] rdata;

   modport master (
      output req, op0, op1, wdata0, wdata1,
      input  ready, gnt_id, done, err, rdata
   );

   modport slave (
      input  req, op0, op1, wdata0, wdata1,
      output ready, gnt_id, done, err, rdata
   );
endinterface

// File: rtl/stack_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational, history updates on upd.
// No backpressure: the caller pulses upd only when it accepts the granted request.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   output logic       gnt_id
);

   logic last;

   // On a tie the requester not granted last wins; a lone requester always wins.
   always_comb begin
      gnt_id = (req == 2'b11) ? ~last : req[1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last <= 1'b1;
      end else if (upd) begin
         last <= gnt_id;
      end
   end

endmodule

// File: rtl/stack_ctrl.sv
// Arbitrated PUSH/POP/TOS controller for an external stack; done 2 cycles after req (3 for POP/TOS).
// One transaction at a time: req is ignored, not queued, while ready is low.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_W
) (
   input  logic                   clk,
   input  logic                   rst,
   stack_ctrl_if.slave            bus,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   full,
   output logic                   empty,
   output logic                   stk_push,
   output logic                   stk_pop,
   output logic                   stk_tos,
   output logic [W-1:0]           stk_din,
   input  logic [W-1:0]           stk_dout
);

   localparam int DW = $clog2(DEPTH) + 1;

   state_t       state;
   logic         win;
   logic         accept;
   logic         win_bad;
   logic [1:0]   win_op;
   logic [W-1:0] win_dat;
   logic [1:0]   op_q;
   logic         bad_q;

   always_comb begin
      full  = (depth == DW'(DEPTH));
      empty = (depth == '0);
   end

   always_comb begin
      accept  = (state == S_IDLE) && (bus.req != 2'b00);
      win_op  = win ? bus.op1 : bus.op0;
      win_dat = win ? bus.wdata1 : bus.wdata0;
      win_bad = (win_op == OP_RSVD) ||
                ((win_op == OP_PUSH) && full) ||
                (((win_op == OP_POP) || (win_op == OP_TOS)) && empty);
   end

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (bus.req),
      .upd    (accept),
      .gnt_id (win)
   );

   // Strobes are decided at the accepting edge so they are registered and
   // live for exactly the ISSUE cycle; depth cannot change while in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         bus.ready  <= 1'b1;
         bus.gnt_id <= 1'b0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.rdata  <= '0;
         depth      <= '0;
         stk_push   <= 1'b0;
         stk_pop    <= 1'b0;
         stk_tos    <= 1'b0;
         stk_din    <= '0;
         op_q       <= OP_PUSH;
         bad_q      <= 1'b0;
      end else begin
         stk_push <= 1'b0;
         stk_pop  <= 1'b0;
         stk_tos  <= 1'b0;
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  bus.gnt_id <= win;
                  bus.ready  <= 1'b0;
                  bus.err    <= 1'b0;
                  op_q       <= win_op;
                  bad_q      <= win_bad;
                  stk_din    <= win_dat;
                  stk_push   <= !win_bad && (win_op == OP_PUSH);
                  stk_pop    <= !win_bad && (win_op == OP_POP);
                  stk_tos    <= !win_bad && (win_op == OP_TOS);
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bad_q) begin
                  bus.err  <= 1'b1;
                  bus.done <= 1'b1;
                  state    <= S_DONE;
               end else if (op_q == OP_PUSH) begin
                  depth    <= depth + DW'(1);
                  bus.done <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  if (op_q == OP_POP) begin
                     depth <= depth - DW'(1);
                  end
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               bus.rdata <= stk_dout;
               bus.done  <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               bus.err   <= 1'b0;
               bus.ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               bus.ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack and a done-driven scoreboard.
// Expected results are hand-computed per transaction and queued at issue time.
module tb_stack_ctrl;
   import stack_ctrl_pkg::*;

   typedef struct {
      logic       g;
      logic       e;
      logic [7:0] rd;
      int         dp;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] depth;
   logic       full;
   logic       empty;
   logic       stk_push;
   logic       stk_pop;
   logic       stk_tos;
   logic [7:0] stk_din;
   logic [7:0] stk_dout;

   int   n_cmp;
   int   n_bad;
   exp_t q[$];
   exp_t mon_e;

   logic [7:0] mem [0:7];
   int         sp;

   stack_ctrl_if #(.W(8)) bus ();

   stack_ctrl #(.DEPTH(8), .W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .depth    (depth),
      .full     (full),
      .empty    (empty),
      .stk_push (stk_push),
      .stk_pop  (stk_pop),
      .stk_tos  (stk_tos),
      .stk_din  (stk_din),
      .stk_dout (stk_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural stack: read data is registered at the end of the pop/tos cycle.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp       <= 0;
         stk_dout <= 8'h00;
      end else begin
         if (stk_push && sp < 8) begin
            mem[sp] <= stk_din;
            sp      <= sp + 1;
         end
         if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
         end
         if (stk_tos && sp > 0) begin
            stk_dout <= mem[sp-1];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && bus.done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", {31'd0, bus.done}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("sb_gnt",   {31'd0, bus.gnt_id}, {31'd0, mon_e.g});
            chk("sb_err",   {31'd0, bus.err},    {31'd0, mon_e.e});
            chk("sb_rdata", {24'd0, bus.rdata},  {24'd0, mon_e.rd});
            chk("sb_depth", {28'd0, depth},      mon_e.dp);
            chk("sb_empty", {31'd0, empty},      (mon_e.dp == 0) ? 32'd1 : 32'd0);
            chk("sb_full",  {31'd0, full},       (mon_e.dp == 8) ? 32'd1 : 32'd0);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b0;
      bus.req = 2'b00;
      #1;
      chk("rst_ready", {31'd0, bus.ready},  32'd1);
      chk("rst_done",  {31'd0, bus.done},   32'd0);
      chk("rst_err",   {31'd0, bus.err},    32'd0);
      chk("rst_gnt",   {31'd0, bus.gnt_id}, 32'd0);
      chk("rst_rdata", {24'd0, bus.rdata},  32'd0);
      chk("rst_depth", {28'd0, depth},      32'd0);
      chk("rst_empty", {31'd0, empty},      32'd1);
      chk("rst_full",  {31'd0, full},       32'd0);
      chk("rst_stb",   {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
      chk("rst_din",   {24'd0, stk_din},    32'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic xact(input string nm, input logic [1:0] r,
                       input logic [1:0] o0, input logic [1:0] o1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [2:0] exp_stb, input logic [7:0] exp_din,
                       input int exp_lat, input logic eg, input logic ee,
                       input logic [7:0] erd, input int edp);
      exp_t t;
      int   n;
      @(negedge clk);
      bus.req = r;  bus.op0 = o0;  bus.op1 = o1;
      bus.wdata0 = d0;  bus.wdata1 = d1;
      t.g = eg;  t.e = ee;  t.rd = erd;  t.dp = edp;
      q.push_back(t);
      @(posedge clk);
      #1 bus.req = 2'b00;
      @(negedge clk);
      chk({nm, ":stb"}, {29'd0, stk_push, stk_pop, stk_tos}, {29'd0, exp_stb});
      if (exp_stb[2]) chk({nm, ":din"}, {24'd0, stk_din}, {24'd0, exp_din});
      chk({nm, ":busy"}, {31'd0, bus.ready}, 32'd0);
      n = 1;
      while (bus.done !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({nm, ":lat"}, (bus.done === 1'b1) ? n : 0, exp_lat);
      @(negedge clk);
      chk({nm, ":ready"}, {31'd0, bus.ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.req = 2'b00;  bus.op0 = OP_PUSH;  bus.op1 = OP_PUSH;
      bus.wdata0 = 8'h00;  bus.wdata1 = 8'h00;
      #2 rst = 1'b0;
      #10 rst = 1'b1;

      // Round-robin on ties starts with requester 0.
      do_reset();
      xact("tie1", 2'b11, OP_PUSH, OP_PUSH, 8'h11, 8'h22, 3'b100, 8'h11, 2, 1'b0, 1'b0, 8'h00, 1);
      xact("tie2", 2'b11, OP_PUSH, OP_PUSH, 8'h33, 8'h44, 3'b100, 8'h44, 2, 1'b1, 1'b0, 8'h00, 2);

      // Push / TOS / POP and the error cases on an empty stack.
      do_reset();
      xact("push5a",  2'b01, OP_PUSH, OP_PUSH, 8'h5A, 8'h00, 3'b100, 8'h5A, 2, 1'b0, 1'b0, 8'h00, 1);
      xact("pusha5",  2'b10, OP_POP,  OP_PUSH, 8'h00, 8'hA5, 3'b100, 8'hA5, 2, 1'b1, 1'b0, 8'h00, 2);
      xact("tos",     2'b01, OP_TOS,  OP_PUSH, 8'h00, 8'h00, 3'b001, 8'h00, 3, 1'b0, 1'b0, 8'hA5, 2);
      xact("pop1",    2'b01, OP_POP,  OP_PUSH, 8'h00, 8'h00, 3'b010, 8'h00, 3, 1'b0, 1'b0, 8'hA5, 1);
      xact("pop2",    2'b10, OP_PUSH, OP_POP,  8'h00, 8'h00, 3'b010, 8'h00, 3, 1'b1, 1'b0, 8'h5A, 0);
      xact("popempt", 2'b10, OP_PUSH, OP_POP,  8'h00, 8'h00, 3'b000, 8'h00, 2, 1'b1, 1'b1, 8'h5A, 0);
      xact("rsvd",    2'b01, OP_RSVD, OP_PUSH, 8'h00, 8'h00, 3'b000, 8'h00, 2, 1'b0, 1'b1, 8'h5A, 0);
      xact("tosempt", 2'b10, OP_PUSH, OP_TOS,  8'h00, 8'h00, 3'b000, 8'h00, 2, 1'b1, 1'b1, 8'h5A, 0);

      // Fill to DEPTH, then overflow attempt.
      for (int i = 0; i < 8; i++) begin
         xact("fill", 2'b01, OP_PUSH, OP_PUSH, 8'h80 + 8'(i), 8'h00, 3'b100, 8'h80 + 8'(i),
              2, 1'b0, 1'b0, 8'h5A, i + 1);
      end
      xact("ovf", 2'b11, OP_PUSH, OP_PUSH, 8'hDD, 8'hEE, 3'b000, 8'h00, 2, 1'b1, 1'b1, 8'h5A, 8);
      chk("ovf_full",  {31'd0, full},  32'd1);
      chk("ovf_depth", {28'd0, depth}, 32'd8);
      xact("popfull", 2'b01, OP_POP, OP_PUSH, 8'h00, 8'h00, 3'b010, 8'h00, 3, 1'b0, 1'b0, 8'h87, 7);

      // Reset while waiting for stack read data abandons the POP.
      @(negedge clk);
      bus.req = 2'b01;  bus.op0 = OP_POP;
      @(posedge clk);
      #1 bus.req = 2'b00;
      @(negedge clk);
      chk("wr_issue_pop", {31'd0, stk_pop}, 32'd1);
      @(negedge clk);
      chk("wr_wait_busy", {31'd0, bus.ready}, 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("wr_ready", {31'd0, bus.ready}, 32'd1);
      chk("wr_depth", {28'd0, depth},     32'd0);
      chk("wr_empty", {31'd0, empty},     32'd1);
      chk("wr_done",  {31'd0, bus.done},  32'd0);
      chk("wr_rdata", {24'd0, bus.rdata}, 32'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      xact("post_push", 2'b01, OP_PUSH, OP_PUSH, 8'h77, 8'h00, 3'b100, 8'h77, 2, 1'b0, 1'b0, 8'h00, 1);
      xact("post_pop",  2'b10, OP_PUSH, OP_POP,  8'h00, 8'h00, 3'b010, 8'h00, 3, 1'b1, 1'b0, 8'h77, 0);

      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
